dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache plus its controller, placed between
//  the cpu data port and data_memory. Serves hits with zero stall cycles. On a miss it

---
 rtl/dcache_controller.sv | 169 ++++++++++++++++
 tb/tb_dcache_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache (8 lines x 4 bytes)
//   with its miss controller, between the cpu data port and data_memory.
//   Hits complete with no stall. A miss writes back a dirty victim block,
//   refills the line, then lets the access hit in IDLE.
//
//   Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0]
//
// Ports
//   CLK            in   1   system clock, posedge
//   RESET          in   1   synchronous, active-high
//   READ / WRITE   in   1   cpu load / store request, held while BUSYWAIT
//   ADDRESS        in   8   cpu byte address
//   WRITEDATA      in   8   cpu store data
//   READDATA       out  8   load data, valid while BUSYWAIT is low
//   BUSYWAIT       out  1   stall to cpu
//   MEM_READ       out  1   block read request
//   MEM_WRITE      out  1   block write request
//   MEM_ADDRESS    out  6   block address {tag,index}
//   MEM_WRITEDATA  out  32  victim block, byte0 in [7:0]
//   MEM_READDATA   in   32  refill block, byte0 in [7:0]
//   MEM_BUSYWAIT   in   1   data_memory busy
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | serving hits; a miss starts WRITEBACK or FETCH
// WRITEBACK  | dirty victim block being written to data_memory
// FETCH      | requested block being read from data_memory
// UPDATE     | refilled block written into the line; returns to IDLE
// -----------------------------------------------------------------------------
module dcache_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam int NUM_BLOCKS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] data_q [NUM_BLOCKS];
    logic [2:0]  tag_q  [NUM_BLOCKS];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;

    logic [31:0] fill_q;
    logic        first_q;
    logic [5:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]  tag_in;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        access;
    logic        hit;
    logic        mem_done;

    assign tag_in = ADDRESS[7:5];
    assign idx    = ADDRESS[4:2];
    assign off    = ADDRESS[1:0];
    assign access = READ | WRITE;
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

    // data_memory may not have raised its busy flag yet during the first
    // cycle of a request, so completion is only accepted after that cycle.
    assign mem_done = !first_q && !MEM_BUSYWAIT;

    assign READDATA = data_q[idx][{off, 3'b000} +: 8];
    assign BUSYWAIT = access && (!hit || (state_q != IDLE));

    always_comb begin
        state_d     = state_q;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (access && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                MEM_WRITE   = 1'b1;
                mem_addr_d  = {tag_q[idx], idx};
                mem_wdata_d = data_q[idx];
                if (mem_done) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                MEM_READ   = 1'b1;
                mem_addr_d = ADDRESS[7:2];
                if (mem_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory address/data outputs hold their last driven value outside
    // WRITEBACK/FETCH, hence the shadow registers.
    assign MEM_ADDRESS   = mem_addr_d;
    assign MEM_WRITEDATA = mem_wdata_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            first_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_q      <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            first_q     <= (state_d != state_q);
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;

            if ((state_q == FETCH) && mem_done) begin
                fill_q <= MEM_READDATA;
            end

            // READ and WRITE together are handled as a store.
            if ((state_q == IDLE) && WRITE && hit) begin
                data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                dirty_q[idx]                    <= 1'b1;
            end

            if (state_q == UPDATE) begin
                data_q[idx]  <= fill_q;
                tag_q[idx]   <= tag_in;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
//   Directed bench for dcache_controller. A small data_memory model holds
//   256 bytes initialised to 0x40 + address; each request keeps MEM_BUSYWAIT
//   high for TMEM-1 cycles, so a memory state lasts TMEM cycles.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

    localparam int TMEM = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int vectors     = 0;
    int miscompares = 0;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // data_memory model
    logic [7:0] mem [256];
    logic [1:0] kind, prev_kind;
    int         mem_cnt, cur_cnt;

    always_comb begin
        kind         = MEM_WRITE ? 2'd2 : (MEM_READ ? 2'd1 : 2'd0);
        cur_cnt      = (kind == prev_kind) ? mem_cnt : 0;
        MEM_BUSYWAIT = (kind != 2'd0) && (cur_cnt < TMEM - 1);
        MEM_READDATA = {mem[{MEM_ADDRESS, 2'd3}], mem[{MEM_ADDRESS, 2'd2}],
                        mem[{MEM_ADDRESS, 2'd1}], mem[{MEM_ADDRESS, 2'd0}]};
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h40 + i);
        prev_kind = 2'd0;
        mem_cnt   = 0;
        forever begin
            @(posedge CLK);
            if (kind != 2'd0) mem_cnt <= cur_cnt + 1;
            if (MEM_WRITE && !MEM_BUSYWAIT) begin
                mem[{MEM_ADDRESS, 2'd0}] <= MEM_WRITEDATA[7:0];
                mem[{MEM_ADDRESS, 2'd1}] <= MEM_WRITEDATA[15:8];
                mem[{MEM_ADDRESS, 2'd2}] <= MEM_WRITEDATA[23:16];
                mem[{MEM_ADDRESS, 2'd3}] <= MEM_WRITEDATA[31:24];
            end
            prev_kind <= kind;
        end
    end

    // Request monitor: counts cycles with each request and remembers its bus.
    int         wb_count = 0;
    int         rd_count = 0;
    logic [5:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  rd_addr = '0;

    always @(negedge CLK) begin
        if (MEM_WRITE) begin
            wb_count <= wb_count + 1;
            wb_addr  <= MEM_ADDRESS;
            wb_data  <= MEM_WRITEDATA;
        end
        if (MEM_READ) begin
            rd_count <= rd_count + 1;
            rd_addr  <= MEM_ADDRESS;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cpu access; returns the number of stalled cycles and the load data.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, output int cyc, output logic [7:0] rdata);
        bit done;
        @(posedge CLK);
        #1;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wd;
        cyc       = 0;
        rdata     = '0;
        done      = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                rdata = READDATA;
                done  = 1'b1;
            end else begin
                cyc++;
                if (cyc > 50) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL timeout addr 0x%0h: BUSYWAIT still high after %0d cycles", addr, cyc);
                    done = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    initial begin
        int         cyc;
        int         wb0, rd0, n;
        logic [7:0] rdata;

        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_readdata", {24'h0, READDATA}, 32'h0);
        check("rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
        check("rst_mem_read", {31'h0, MEM_READ}, 32'h0);
        check("rst_mem_write", {31'h0, MEM_WRITE}, 32'h0);
        check("rst_mem_address", {26'h0, MEM_ADDRESS}, 32'h0);
        check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);

        // 1: cold read miss
        wb0 = wb_count; rd0 = rd_count;
        access(1'b1, 1'b0, 8'h00, 8'h00, cyc, rdata);
        check("t1_latency", cyc, TMEM + 2);
        check("t1_no_writeback", wb_count - wb0, 0);
        check("t1_fetch_cycles", rd_count - rd0, TMEM);
        check("t1_fetch_addr", {26'h0, rd_addr}, 32'h00);
        check("t1_readdata", {24'h0, rdata}, 32'h40);

        // 2: hits in the refilled line
        access(1'b1, 1'b0, 8'h01, 8'h00, cyc, rdata);
        check("t2_hit1_stall", cyc, 0);
        check("t2_hit1_data", {24'h0, rdata}, 32'h41);
        access(1'b1, 1'b0, 8'h02, 8'h00, cyc, rdata);
        check("t2_hit2_stall", cyc, 0);
        check("t2_hit2_data", {24'h0, rdata}, 32'h42);
        access(1'b1, 1'b0, 8'h03, 8'h00, cyc, rdata);
        check("t2_hit3_stall", cyc, 0);
        check("t2_hit3_data", {24'h0, rdata}, 32'h43);

        // 3: write-allocate miss, then read back
        wb0 = wb_count;
        access(1'b0, 1'b1, 8'h05, 8'hAB, cyc, rdata);
        check("t3_write_latency", cyc, TMEM + 2);
        check("t3_no_writeback", wb_count - wb0, 0);
        check("t3_fetch_addr", {26'h0, rd_addr}, 32'h01);
        access(1'b1, 1'b0, 8'h05, 8'h00, cyc, rdata);
        check("t3_read_stall", cyc, 0);
        check("t3_read_data", {24'h0, rdata}, 32'hAB);
        access(1'b1, 1'b0, 8'h04, 8'h00, cyc, rdata);
        check("t3_neighbour_data", {24'h0, rdata}, 32'h44);

        // 4: conflict miss on dirty line -> writeback then fetch
        wb0 = wb_count;
        access(1'b1, 1'b0, 8'h25, 8'h00, cyc, rdata);
        check("t4_latency", cyc, 2 * TMEM + 2);
        check("t4_wb_cycles", wb_count - wb0, TMEM);
        check("t4_wb_addr", {26'h0, wb_addr}, 32'h01);
        check("t4_wb_data", wb_data, 32'h4746AB44);
        check("t4_fetch_addr", {26'h0, rd_addr}, 32'h09);
        check("t4_readdata", {24'h0, rdata}, 32'h65);
        check("t4_mem_byte05", {24'h0, mem[8'h05]}, 32'hAB);

        // 5: reset in the middle of FETCH
        @(posedge CLK);
        #1;
        READ    = 1'b1;
        ADDRESS = 8'h30;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!MEM_READ && n < 20);
        check("t5_fetch_started", {31'h0, MEM_READ}, 32'h1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ  = 1'b0;
        @(negedge CLK);
        check("t5_mem_read", {31'h0, MEM_READ}, 32'h0);
        check("t5_busywait", {31'h0, BUSYWAIT}, 32'h0);
        check("t5_mem_address", {26'h0, MEM_ADDRESS}, 32'h0);
        check("t5_readdata", {24'h0, READDATA}, 32'h0);
        wb0 = wb_count;
        access(1'b1, 1'b0, 8'h05, 8'h00, cyc, rdata);
        check("t5_miss_latency", cyc, TMEM + 2);
        check("t5_no_writeback", wb_count - wb0, 0);
        check("t5_readdata_after", {24'h0, rdata}, 32'hAB);

        // 6: READ and WRITE together act as a store
        wb0 = wb_count;
        access(1'b1, 1'b1, 8'h10, 8'h5A, cyc, rdata);
        check("t6_latency", cyc, TMEM + 2);
        check("t6_no_writeback", wb_count - wb0, 0);
        access(1'b1, 1'b0, 8'h10, 8'h00, cyc, rdata);
        check("t6_read_stall", cyc, 0);
        check("t6_read_data", {24'h0, rdata}, 32'h5A);
        access(1'b1, 1'b0, 8'h11, 8'h00, cyc, rdata);
        check("t6_neighbour_data", {24'h0, rdata}, 32'h51);

        // write hit on a valid line: no stall, byte updated
        access(1'b0, 1'b1, 8'h11, 8'h77, cyc, rdata);
        check("wh_stall", cyc, 0);
        access(1'b1, 1'b0, 8'h11, 8'h00, cyc, rdata);
        check("wh_read_data", {24'h0, rdata}, 32'h77);
        check("wh_other_byte", {24'h0, mem[8'h11]}, 32'h51);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
